// File: rtl/uniboard_pkg.sv
// Types and constants shared by the uniboard command path.
package uniboard_pkg;

  localparam int unsigned REG_ADDR_W = 7;

  localparam logic [7:0] SYNC_BYTE = 8'h7E;
  localparam logic [7:0] NACK_CMD  = 8'hFF;

  localparam logic [REG_ADDR_W-1:0] LED_ADDR       = 7'h00;
  localparam logic [REG_ADDR_W-1:0] STEPPER0_ADDR  = 7'h10;
  localparam logic [REG_ADDR_W-1:0] STEPPER1_ADDR  = 7'h11;
  localparam logic [REG_ADDR_W-1:0] MOTOR_PWM_ADDR = 7'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_DATA,
    ST_GET_SUM,
    ST_EXEC,
    ST_READ_WAIT,
    ST_TX_SYNC,
    ST_TX_CMD,
    ST_TX_DATA,
    ST_TX_SUM
  } cmd_state_t;

  // Sub-steps of every reply byte: request, let tx_busy rise, wait for it to fall.
  typedef enum logic [1:0] {
    PH_SEND,
    PH_HOLD,
    PH_WAIT
  } tx_phase_t;

  function automatic cmd_state_t next_tx_state(input cmd_state_t s);
    case (s)
      ST_TX_SYNC: return ST_TX_CMD;
      ST_TX_CMD:  return ST_TX_DATA;
      ST_TX_DATA: return ST_TX_SUM;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_command_decoder_if.sv
// UART byte streams and register bus seen by the command decoder.
interface uart_command_decoder_if;
  import uniboard_pkg::*;

  logic [7:0]            rx_data;
  logic                  rx_drdy;
  logic [7:0]            tx_data;
  logic                  tx_send;
  logic                  tx_busy;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [7:0]            reg_rdata;
  logic                  overrun;

  modport master (
    input  rx_data, rx_drdy, tx_busy, reg_rdata,
    output tx_data, tx_send, reg_addr, reg_wdata, reg_we, reg_re, overrun
  );

  modport slave (
    output rx_data, rx_drdy, tx_busy, reg_rdata,
    input  tx_data, tx_send, reg_addr, reg_wdata, reg_we, reg_re, overrun
  );

endinterface

// File: rtl/byte_timeout.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
module byte_timeout #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/uart_command_decoder.sv
// Frames SYNC/CMD/DATA/SUM request packets, performs one register access
// and streams back a SYNC/CMD/DATA/SUM reply through the UART transmitter.
module uart_command_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [7:0]  SYNC_BYTE      = uniboard_pkg::SYNC_BYTE
) (
  input logic                    clk,
  input logic                    reset,
  uart_command_decoder_if.master bus
);
  import uniboard_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  cmd_state_t            state_reg, state_next;
  tx_phase_t             phase_reg, phase_next;
  logic [7:0]            cmd_reg, sum_reg, reply_data_reg, tx_data_reg, reply_cmd;
  logic [REG_ADDR_W-1:0] reg_addr_reg;
  logic [7:0]            reg_wdata_reg;
  logic                  sum_ok_reg, reg_we_reg, reg_re_reg, overrun_reg;
  logic                  in_get, in_reply, timer_load, timer_expired, tx_send_next;

  assign in_get     = state_reg inside {ST_GET_CMD, ST_GET_DATA, ST_GET_SUM};
  assign in_reply   = !in_get && (state_reg != ST_IDLE);
  assign timer_load = bus.rx_drdy && !in_reply;
  assign reply_cmd  = sum_ok_reg ? cmd_reg : NACK_CMD;

  byte_timeout #(.WIDTH(TW)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(TW'(TIMEOUT_CYCLES - 1)),
    .enable    (in_get),
    .expired   (timer_expired)
  );

  // A byte arriving in the same cycle as expiry wins over the timeout.
  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    tx_send_next = 1'b0;
    unique case (state_reg)
      ST_IDLE: if (bus.rx_drdy && bus.rx_data == SYNC_BYTE) state_next = ST_GET_CMD;
      ST_GET_CMD: begin
        if (bus.rx_drdy)        state_next = ST_GET_DATA;
        else if (timer_expired) state_next = ST_IDLE;
      end
      ST_GET_DATA: begin
        if (bus.rx_drdy)        state_next = ST_GET_SUM;
        else if (timer_expired) state_next = ST_IDLE;
      end
      ST_GET_SUM: begin
        if (bus.rx_drdy)        state_next = ST_EXEC;
        else if (timer_expired) state_next = ST_IDLE;
      end
      ST_EXEC:      state_next = (sum_ok_reg && !cmd_reg[7]) ? ST_READ_WAIT : ST_TX_SYNC;
      ST_READ_WAIT: state_next = ST_TX_SYNC;
      ST_TX_SYNC, ST_TX_CMD, ST_TX_DATA, ST_TX_SUM: begin
        unique case (phase_reg)
          PH_SEND: if (!bus.tx_busy) begin
            tx_send_next = 1'b1;
            phase_next   = PH_HOLD;
          end
          PH_HOLD: phase_next = PH_WAIT;
          PH_WAIT: if (!bus.tx_busy) begin
            phase_next = PH_SEND;
            state_next = next_tx_state(state_reg);
          end
          default: phase_next = PH_SEND;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= PH_SEND;
      cmd_reg        <= 8'h00;
      sum_reg        <= 8'h00;
      sum_ok_reg     <= 1'b0;
      reply_data_reg <= 8'h00;
      tx_data_reg    <= 8'h00;
      reg_addr_reg   <= '0;
      reg_wdata_reg  <= 8'h00;
      reg_we_reg     <= 1'b0;
      reg_re_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      reg_we_reg <= 1'b0;
      reg_re_reg <= 1'b0;
      if (bus.rx_drdy && in_reply) overrun_reg <= 1'b1;
      if (bus.rx_drdy) begin
        unique case (state_reg)
          ST_GET_CMD: begin
            cmd_reg      <= bus.rx_data;
            reg_addr_reg <= bus.rx_data[REG_ADDR_W-1:0];
            sum_reg      <= bus.rx_data;
          end
          ST_GET_DATA: begin
            reg_wdata_reg <= bus.rx_data;
            sum_reg       <= sum_reg + bus.rx_data;
          end
          ST_GET_SUM: begin
            sum_ok_reg <= (bus.rx_data == sum_reg);
            reg_we_reg <= (bus.rx_data == sum_reg) && cmd_reg[7];
            reg_re_reg <= (bus.rx_data == sum_reg) && !cmd_reg[7];
          end
          default: ;
        endcase
      end
      if (state_reg == ST_EXEC)
        reply_data_reg <= (sum_ok_reg && cmd_reg[7]) ? reg_wdata_reg : 8'h00;
      if (state_reg == ST_READ_WAIT)
        reply_data_reg <= bus.reg_rdata;
      // Each reply byte is latched on entry to its state so it is stable before tx_send.
      if (state_next != state_reg) begin
        unique case (state_next)
          ST_TX_SYNC: tx_data_reg <= SYNC_BYTE;
          ST_TX_CMD:  tx_data_reg <= reply_cmd;
          ST_TX_DATA: tx_data_reg <= reply_data_reg;
          ST_TX_SUM:  tx_data_reg <= reply_cmd + reply_data_reg;
          default: ;
        endcase
      end
    end
  end

  assign bus.tx_data   = tx_data_reg;
  assign bus.tx_send   = tx_send_next && !reset;
  assign bus.reg_addr  = reg_addr_reg;
  assign bus.reg_wdata = reg_wdata_reg;
  assign bus.reg_we    = reg_we_reg;
  assign bus.reg_re    = reg_re_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Directed checks of the command decoder with a small transmitter and register-read model.
module tb_uart_command_decoder;

  localparam int TMO = 40;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] rd_value;
  int cyc = 0;
  int busy_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  // Monitor-owned records
  int we_count = 0, re_count = 0, hold_errs = 0;
  int we_cyc = 0, re_cyc = 0, last_drdy_cyc = 0;
  logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, held_byte = 0;
  logic [7:0] tx_log[$];
  int tx_cyc_log[$];

  // Stimulus-owned snapshots
  int we_base, re_base, tx_base, hold_base, sum_cyc;

  uart_command_decoder_if bus();

  uart_command_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transmitter: busy from the cycle after tx_send for 6 cycles.
  always @(posedge clk) begin
    if (bus.tx_send) begin
      bus.tx_busy <= 1'b1;
      busy_cnt    <= 6;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt    <= 0;
      bus.tx_busy <= 1'b0;
    end
  end

  // Read data is only valid in the single cycle after reg_re.
  always @(posedge clk) bus.reg_rdata <= bus.reg_re ? rd_value : 8'h00;

  always @(negedge clk) begin
    if (bus.rx_drdy) last_drdy_cyc = cyc;
    if (bus.reg_we) begin
      we_count++; we_cyc = cyc; we_addr = 8'(bus.reg_addr); we_data = bus.reg_wdata;
    end
    if (bus.reg_re) begin
      re_count++; re_cyc = cyc; re_addr = 8'(bus.reg_addr);
    end
    if (bus.tx_send) begin
      tx_log.push_back(bus.tx_data); tx_cyc_log.push_back(cyc); held_byte = bus.tx_data;
    end else if (bus.tx_busy === 1'b1 && bus.tx_data !== held_byte) begin
      hold_errs++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_drdy = 1'b1;
    tick(1);
    bus.rx_drdy = 1'b0;
  endtask

  task automatic snap();
    we_base = we_count; re_base = re_count; tx_base = tx_log.size(); hold_base = hold_errs;
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    sum_cyc = last_drdy_cyc;
  endtask

  task automatic wait_tx(input string tag, input int n);
    int k = 0;
    while ((tx_log.size() < tx_base + n || bus.tx_busy !== 1'b0) && k < 500) begin
      tick(1);
      k++;
    end
    check({tag, "_done"}, 32'(k < 500), 32'd1);
  endtask

  // Waits for a full reply, then checks its bytes, first-byte latency and data hold.
  task automatic check_reply(input string tag, input logic [31:0] exp_word, input int exp_delay);
    logic [31:0] word;
    wait_tx(tag, 4);
    word = 32'hDEADBEEF;
    if (tx_log.size() >= tx_base + 4)
      word = {tx_log[tx_base], tx_log[tx_base+1], tx_log[tx_base+2], tx_log[tx_base+3]};
    check({tag, "_reply"}, word, exp_word);
    if (exp_delay > 0 && tx_cyc_log.size() > tx_base)
      check({tag, "_tx_lat"}, 32'(tx_cyc_log[tx_base] - sum_cyc), 32'(exp_delay));
    check({tag, "_hold"}, 32'(hold_errs - hold_base), 32'd0);
    tick(3);
  endtask

  initial begin
    reset = 1'b1; rd_value = 8'h00;
    bus.rx_data = 8'h00; bus.rx_drdy = 1'b0;
    tick(3);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_tx_send", 32'(bus.tx_send), 32'h0);
    check("rst_reg_addr", 32'(bus.reg_addr), 32'h0);
    check("rst_reg_wdata", 32'(bus.reg_wdata), 32'h0);
    check("rst_strobes_ovr", {29'd0, bus.reg_we, bus.reg_re, bus.overrun}, 32'h0);
    reset = 1'b0;
    tick(2);

    // Write 0x3C to address 0x05
    snap();
    send_pkt(8'h7E, 8'h85, 8'h3C, 8'hC1);
    check_reply("wr", 32'h7E853CC1, 2);
    check("wr_we_count", 32'(we_count - we_base), 32'd1);
    check("wr_re_count", 32'(re_count - re_base), 32'd0);
    check("wr_addr_data", {16'd0, we_addr, we_data}, 32'h053C);
    check("wr_we_lat", 32'(we_cyc - sum_cyc), 32'd1);

    // Read from address 0x05, register returns 0xA5
    rd_value = 8'hA5;
    snap();
    send_pkt(8'h7E, 8'h05, 8'h00, 8'h05);
    check_reply("rd", 32'h7E05A5AA, 3);
    check("rd_re_count", 32'(re_count - re_base), 32'd1);
    check("rd_we_count", 32'(we_count - we_base), 32'd0);
    check("rd_addr", 32'(re_addr), 32'h05);
    check("rd_re_lat", 32'(re_cyc - sum_cyc), 32'd1);

    // Bad checksum: NACK reply, no register access
    snap();
    send_pkt(8'h7E, 8'h85, 8'h3C, 8'h00);
    check_reply("bad", 32'h7EFF00FF, 2);
    check("bad_strobes", 32'((we_count - we_base) + (re_count - re_base)), 32'd0);

    // Byte landing exactly on the expiry cycle is still accepted
    snap();
    send_byte(8'h7E); send_byte(8'h85);
    tick(TMO - 1);
    send_byte(8'h3C); send_byte(8'hC1);
    sum_cyc = last_drdy_cyc;
    check_reply("tmo_edge", 32'h7E853CC1, 2);
    check("tmo_edge_we", 32'(we_count - we_base), 32'd1);

    // Silence of TIMEOUT_CYCLES aborts; next SYNC starts a fresh packet
    snap();
    send_byte(8'h7E); send_byte(8'h85);
    tick(TMO);
    check("tmo_no_reply", 32'(tx_log.size() - tx_base), 32'd0);
    check("tmo_no_we", 32'(we_count - we_base), 32'd0);
    send_pkt(8'h7E, 8'h85, 8'h3C, 8'hC1);
    check_reply("tmo_after", 32'h7E853CC1, 2);
    check("tmo_after_we", 32'(we_count - we_base), 32'd1);

    // Byte injected during a reply is dropped and sets sticky overrun
    check("ovr_before", 32'(bus.overrun), 32'd0);
    snap();
    send_pkt(8'h7E, 8'h85, 8'h3C, 8'hC1);
    wait_tx("ovr_mid", 2);
    send_byte(8'h55);
    check_reply("ovr", 32'h7E853CC1, 2);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    tick(20);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Reset while in TX_DATA abandons the reply
    snap();
    send_pkt(8'h7E, 8'h8A, 8'h11, 8'h9B);
    begin
      int k = 0;
      while (tx_log.size() < tx_base + 3 && k < 500) begin
        tick(1);
        k++;
      end
      check("rst_tx_reach", 32'(k < 500), 32'd1);
    end
    reset = 1'b1;
    tick(1);
    check("rst_mid_send", 32'(bus.tx_send), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(30);
    check("rst_mid_bytes", 32'(tx_log.size() - tx_base), 32'd3);
    check("rst_mid_outs", {bus.tx_data, 1'b0, bus.reg_addr, bus.reg_wdata, 5'd0,
                           bus.reg_we, bus.reg_re, bus.overrun}, 32'h0);

    // Normal read after the interrupted reply
    rd_value = 8'hC3;
    snap();
    send_pkt(8'h7E, 8'h12, 8'h00, 8'h12);
    check_reply("post_rst", 32'h7E12C3D5, 3);
    check("post_rst_addr", 32'(re_addr), 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
